regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_if.sv | 43 ++++
 rtl/regfile_arbiter.sv | 94 +++++++++
 tb/tb_regfile_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Bundle of the two requester ports and the register-file port of regfile_arbiter.
// Handshake: a requester holds req (and we/addr/wdata stable) until it sees a one-cycle
// ack; a read then returns one cycle later as a one-cycle rvalid pulse with rdata valid.
interface regfile_arbiter_if;
  logic       a_req;
  logic       a_we;
  logic [1:0] a_addr;
  logic [3:0] a_wdata;
  logic       a_ack;
  logic       a_rvalid;
  logic [3:0] a_rdata;

  logic       b_req;
  logic       b_we;
  logic [1:0] b_addr;
  logic [3:0] b_wdata;
  logic       b_ack;
  logic       b_rvalid;
  logic [3:0] b_rdata;

  logic       rf_we;
  logic [1:0] rf_addr;
  logic [3:0] rf_data_in;
  logic [3:0] rf_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output rf_we, rf_addr, rf_data_in,
    input  rf_data_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  rf_we, rf_addr, rf_data_in,
    output rf_data_out
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 4x4 register file, one access in flight at a time.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module regfile_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  regfile_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       win_a_q;
  logic       win_we_q;
  logic       grant;
  logic       pick_a;
  logic       sel_we;
  logic [1:0] sel_addr;
  logic [3:0] sel_wdata;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic       last_grant_b;
`endif

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    pick_a    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          grant   = 1'b1;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
          pick_a  = bus.a_req;
`else
          // On a tie, the requester that was not granted last goes first.
          pick_a  = bus.a_req && (!bus.b_req || last_grant_b);
`endif
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = win_we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sel_we    = pick_a ? bus.a_we    : bus.b_we;
    sel_addr  = pick_a ? bus.a_addr  : bus.b_addr;
    sel_wdata = pick_a ? bus.a_wdata : bus.b_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      win_a_q        <= 1'b0;
      win_we_q       <= 1'b0;
      bus.a_ack      <= 1'b0;
      bus.b_ack      <= 1'b0;
      bus.a_rvalid   <= 1'b0;
      bus.b_rvalid   <= 1'b0;
      bus.rf_we      <= 1'b0;
      bus.rf_addr    <= 2'd0;
      bus.rf_data_in <= 4'd0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      last_grant_b   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      bus.a_ack    <= grant && pick_a;
      bus.b_ack    <= grant && !pick_a;
      bus.rf_we    <= grant && sel_we;
      // Read data comes back the cycle after the read address was presented.
      bus.a_rvalid <= (state_q == ISSUE) && !win_we_q && win_a_q;
      bus.b_rvalid <= (state_q == ISSUE) && !win_we_q && !win_a_q;
      if (grant) begin
        win_a_q        <= pick_a;
        win_we_q       <= sel_we;
        bus.rf_addr    <= sel_addr;
        bus.rf_data_in <= sel_wdata;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        last_grant_b   <= !pick_a;
`endif
      end
    end
  end

  assign bus.a_rdata = bus.rf_data_out;
  assign bus.b_rdata = bus.rf_data_out;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed and randomized bench for regfile_arbiter with a behavioural register file and model.
module tb_regfile_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file: write on rf_we, registered read of rf_addr
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_addr] <= bus.rf_data_in;
    bus.rf_data_out <= mem[bus.rf_addr];
  end

  // reference model state
  logic [3:0] shadow [4];
  bit         rr_last_a;
  logic [1:0] cur_addr;
  logic [3:0] cur_din;

  // per-cycle expectations for one step (index = cycles after requests raised)
  bit         e_ack   [2][8];
  bit         e_rv    [2][8];
  logic [3:0] e_rd    [2];
  bit         e_issue [8];
  bit         e_we    [8];
  logic [1:0] e_addr  [8];
  logic [3:0] e_din   [8];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tie_goes_to_a();
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return !rr_last_a;
`endif
  endfunction

  // schedule one access starting at cycle t; returns the next cycle it can start
  function automatic int serve(input int who, input int t, input bit we,
                               input logic [1:0] addr, input logic [3:0] wd);
    e_ack[who][t] = 1'b1;
    e_issue[t]    = 1'b1;
    e_we[t]       = we;
    e_addr[t]     = addr;
    e_din[t]      = wd;
    rr_last_a     = (who == 0);
    if (we) begin
      shadow[addr] = wd;
      return t + 2;
    end
    e_rv[who][t+1] = 1'b1;
    e_rd[who]      = shadow[addr];
    return t + 3;
  endfunction

  task automatic check_cycle(input int t);
    if (e_issue[t]) begin
      cur_addr = e_addr[t];
      cur_din  = e_din[t];
    end
    chk($sformatf("a_ack@%0d", t), {7'd0, bus.a_ack}, {7'd0, e_ack[0][t]});
    chk($sformatf("b_ack@%0d", t), {7'd0, bus.b_ack}, {7'd0, e_ack[1][t]});
    chk($sformatf("a_rvalid@%0d", t), {7'd0, bus.a_rvalid}, {7'd0, e_rv[0][t]});
    chk($sformatf("b_rvalid@%0d", t), {7'd0, bus.b_rvalid}, {7'd0, e_rv[1][t]});
    chk($sformatf("rf_we@%0d", t), {7'd0, bus.rf_we}, {7'd0, e_issue[t] && e_we[t]});
    chk($sformatf("rf_addr@%0d", t), {6'd0, bus.rf_addr}, {6'd0, cur_addr});
    chk($sformatf("rf_data_in@%0d", t), {4'd0, bus.rf_data_in}, {4'd0, cur_din});
    if (e_rv[0][t]) chk($sformatf("a_rdata@%0d", t), {4'd0, bus.a_rdata}, {4'd0, e_rd[0]});
    if (e_rv[1][t]) chk($sformatf("b_rdata@%0d", t), {4'd0, bus.b_rdata}, {4'd0, e_rd[1]});
  endtask

  // driver: raise up to two requests together, run 7 cycles, drop each req on its ack
  task automatic run_step(input bit a_en, input bit a_we, input logic [1:0] a_addr,
                          input logic [3:0] a_wd, input bit b_en, input bit b_we,
                          input logic [1:0] b_addr, input logic [3:0] b_wd);
    int nt;
    for (int i = 0; i < 8; i++) begin
      e_ack[0][i] = 0; e_ack[1][i] = 0; e_rv[0][i] = 0; e_rv[1][i] = 0;
      e_issue[i] = 0; e_we[i] = 0; e_addr[i] = 0; e_din[i] = 0;
    end
    nt = 1;
    if (a_en && b_en) begin
      if (tie_goes_to_a()) begin
        nt = serve(0, nt, a_we, a_addr, a_wd);
        nt = serve(1, nt, b_we, b_addr, b_wd);
      end else begin
        nt = serve(1, nt, b_we, b_addr, b_wd);
        nt = serve(0, nt, a_we, a_addr, a_wd);
      end
    end else if (a_en) begin
      nt = serve(0, nt, a_we, a_addr, a_wd);
    end else if (b_en) begin
      nt = serve(1, nt, b_we, b_addr, b_wd);
    end
    @(posedge clk); #1;
    bus.a_req = a_en; bus.a_we = a_we; bus.a_addr = a_addr; bus.a_wdata = a_wd;
    bus.b_req = b_en; bus.b_we = b_we; bus.b_addr = b_addr; bus.b_wdata = b_wd;
    for (int t = 1; t < 8; t++) begin
      @(posedge clk); #1;
      check_cycle(t);
      if (bus.a_ack) bus.a_req = 1'b0;
      if (bus.b_ack) bus.b_req = 1'b0;
    end
    chk("a_req_served", {7'd0, bus.a_req}, 8'd0);
    chk("b_req_served", {7'd0, bus.b_req}, 8'd0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int         a_grants;
    tests = 0;
    fails = 0;
    rr_last_a = 1'b0;
    cur_addr = 2'd0;
    cur_din  = 4'd0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    chk("rst_a_ack", {7'd0, bus.a_ack}, 8'd0);
    chk("rst_b_ack", {7'd0, bus.b_ack}, 8'd0);
    chk("rst_a_rvalid", {7'd0, bus.a_rvalid}, 8'd0);
    chk("rst_b_rvalid", {7'd0, bus.b_rvalid}, 8'd0);
    chk("rst_rf_we", {7'd0, bus.rf_we}, 8'd0);
    chk("rst_rf_addr", {6'd0, bus.rf_addr}, 8'd0);
    chk("rst_rf_data_in", {4'd0, bus.rf_data_in}, 8'd0);
    chk("rst_state_idle", {6'd0, dbg_state}, 8'd0);

    // A write then read of addr 2
    run_step(1, 1, 2'd2, 4'hA, 0, 0, 2'd0, 4'h0);
    run_step(1, 0, 2'd2, 4'h0, 0, 0, 2'd0, 4'h0);
    // B write then read of addr 0
    run_step(0, 0, 2'd0, 4'h0, 1, 1, 2'd0, 4'hF);
    run_step(0, 0, 2'd0, 4'h0, 1, 0, 2'd0, 4'h6);
    // tie, fills the remaining registers
    run_step(1, 1, 2'd3, 4'h3, 1, 1, 2'd1, 4'h1);
    // tie: A writes addr 1, B reads addr 1 in the same step
    run_step(1, 1, 2'd1, 4'h9, 1, 0, 2'd1, 4'h2);

    // both requesters hold req high continuously
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 2'd3; bus.a_wdata = 4'hC;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 2'd1; bus.b_wdata = 4'h5;
    for (int k = 0; k < 6; k++) begin
      if (tie_goes_to_a()) begin
        exp_q.push_back(8'hA);
        shadow[3] = 4'hC; cur_addr = 2'd3; cur_din = 4'hC; rr_last_a = 1'b1;
      end else begin
        exp_q.push_back(8'hB);
        shadow[1] = 4'h5; cur_addr = 2'd1; cur_din = 4'h5; rr_last_a = 1'b0;
      end
    end
    a_grants = 0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      if (t % 2 == 1) begin
        logic [7:0] who;
        who = bus.a_ack ? 8'hA : (bus.b_ack ? 8'hB : 8'h0);
        chk($sformatf("cont_grant@%0d", t), who, exp_q.pop_front());
        chk($sformatf("cont_both_ack@%0d", t), {7'd0, bus.a_ack && bus.b_ack}, 8'd0);
        if (bus.a_ack) a_grants++;
      end else begin
        chk($sformatf("cont_idle_we@%0d", t), {7'd0, bus.rf_we}, 8'd0);
      end
    end
    bus.a_req = 0; bus.b_req = 0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    chk("cont_a_grants", a_grants[7:0], 8'd6);
`else
    chk("cont_a_grants", a_grants[7:0], 8'd3);
`endif
    chk("cont_rf_addr_hold", {6'd0, bus.rf_addr}, {6'd0, cur_addr});

    // randomized transactions against the model
    for (int n = 0; n < 16; n++) begin
      bit a_en, b_en;
      a_en = 1'($urandom_range(0, 1));
      b_en = 1'($urandom_range(0, 1));
      if (!a_en && !b_en) a_en = 1'b1;
      run_step(a_en, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
               b_en, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom));
    end

    // reset asserted while an A read is in flight
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 2'd2; bus.a_wdata = 4'h7;
    @(posedge clk); #1;
    chk("mid_a_ack", {7'd0, bus.a_ack}, 8'd1);
    bus.a_req = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_no_rvalid", {7'd0, bus.a_rvalid}, 8'd0);
    chk("mid_state_idle", {6'd0, dbg_state}, 8'd0);
    chk("mid_rf_addr", {6'd0, bus.rf_addr}, 8'd0);
    chk("mid_rf_data_in", {4'd0, bus.rf_data_in}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_rvalid", {7'd0, bus.a_rvalid}, 8'd0);
    chk("post_rst_no_ack", {7'd0, bus.a_ack || bus.b_ack}, 8'd0);
    rr_last_a = 1'b0;
    cur_addr  = 2'd0;
    cur_din   = 4'd0;
    // tie after reset: A must win
    run_step(1, 0, 2'd3, 4'h0, 1, 0, 2'd1, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
